// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the counter run sequencer: state encoding and
// default datapath widths.
package counter_run_ctrl_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int RPT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/counter_run_ctrl_core.sv
// Counter datapath: CNT_W-bit up-counter with synchronous clear, enable and
// wrap to zero once the count reaches the supplied limit.
module counter_core
  import counter_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_limit
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == i_limit);

  // Count register: clear has priority over enable; wraps at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_at_limit ? '0 : r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run sequencer: latches a run request, drives the counter core through
// 0..limit the requested number of times (or until stopped) and reports
// terminal counts, completion and aborts.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_limit,
  input  logic [RPT_W-1:0] i_repeat,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc,
  output logic [RPT_W-1:0] o_run_idx,
  output logic             o_done,
  output logic             o_abort
);

  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [RPT_W-1:0] r_repeat;
  logic             r_mode;
  logic [RPT_W-1:0] r_run_idx;
  logic [RPT_W-1:0] w_idx_nxt;
  logic             w_at_limit;
  logic             w_tc;
  logic             w_last;
  logic             w_clr;
  logic             w_en;

  // Counter is held at zero outside RUN and cleared by a stop so ABORT shows 0.
  assign w_clr = (r_state != RUN) || i_stop;
  assign w_en  = (r_state == RUN);

  counter_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .i_limit    (r_limit),
    .o_cnt      (o_cnt),
    .o_at_limit (w_at_limit)
  );

  // A stop in the terminal cycle suppresses the terminal count entirely.
  assign w_tc      = (r_state == RUN) && w_at_limit && !i_stop;
  assign w_idx_nxt = r_run_idx + RPT_ONE;
  assign w_last    = (w_idx_nxt == r_repeat);

  assign o_tc      = w_tc;
  assign o_busy    = (r_state == RUN);
  assign o_done    = (r_state == DONE);
  assign o_abort   = (r_state == ABORT);
  assign o_run_idx = r_run_idx;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE and ABORT are single-cycle pulses back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (i_start) w_state_nxt = RUN;
      RUN: begin
        if (i_stop) begin
          w_state_nxt = ABORT;
        end else if (w_tc && !r_mode && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run parameters latched at start; a zero repeat count is stored as one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_limit   <= '0;
      r_repeat  <= '0;
      r_mode    <= 1'b0;
      r_run_idx <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_limit   <= i_limit;
      r_repeat  <= (i_repeat == '0) ? RPT_ONE : i_repeat;
      r_mode    <= i_mode;
      r_run_idx <= '0;
    end else if (w_tc) begin
      r_run_idx <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Testbench for counter_run_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-count based reference model.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_stop;
  logic       i_mode;
  logic [3:0] i_limit;
  logic [3:0] i_repeat;
  logic       o_busy;
  logic [3:0] o_cnt;
  logic       o_tc;
  logic [3:0] o_run_idx;
  logic       o_done;
  logic       o_abort;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase 0 idle, 1 run, 2 done, 3 abort.
  // While running, m_k counts cycles since the run began; count and run
  // index follow arithmetically from it.
  int m_ph   = 0;
  int m_k    = 0;
  int m_lim  = 0;
  int m_rpt  = 1;
  bit m_cont = 1'b0;
  int m_idx  = 0;

  counter_run_ctrl #(
    .CNT_W (4),
    .RPT_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_mode    (i_mode),
    .i_limit   (i_limit),
    .i_repeat  (i_repeat),
    .o_busy    (o_busy),
    .o_cnt     (o_cnt),
    .o_tc      (o_tc),
    .o_run_idx (o_run_idx),
    .o_done    (o_done),
    .o_abort   (o_abort)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph  = 0;
    m_k   = 0;
    m_idx = 0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},  o_busy,    0);
    check_eq({tag, "_cnt"},   o_cnt,     0);
    check_eq({tag, "_tc"},    o_tc,      0);
    check_eq({tag, "_idx"},   o_run_idx, 0);
    check_eq({tag, "_done"},  o_done,    0);
    check_eq({tag, "_abort"}, o_abort,   0);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to the state the next rising edge produces.
  task automatic cyc(input bit st, input bit sp, input bit md,
                     input int lim, input int rpt);
    int  per;
    int  cnt_e;
    int  idx_e;
    int  runs;
    bit  tc_e;
    @(negedge clk);
    i_start  = st;
    i_stop   = sp;
    i_mode   = md;
    i_limit  = 4'(lim);
    i_repeat = 4'(rpt);
    #1;
    per   = m_lim + 1;
    runs  = m_k / per;
    cnt_e = (m_ph == 1) ? (m_k % per) : 0;
    idx_e = (m_ph == 1) ? (runs % 16) : m_idx;
    tc_e  = (m_ph == 1) && (cnt_e == m_lim) && !sp;
    check_eq("busy",  o_busy,    int'(m_ph == 1));
    check_eq("cnt",   o_cnt,     cnt_e);
    check_eq("tc",    o_tc,      int'(tc_e));
    check_eq("idx",   o_run_idx, idx_e);
    check_eq("done",  o_done,    int'(m_ph == 2));
    check_eq("abort", o_abort,   int'(m_ph == 3));
    case (m_ph)
      0: if (st) begin
        m_ph   = 1;
        m_k    = 0;
        m_lim  = lim;
        m_rpt  = (rpt == 0) ? 1 : rpt;
        m_cont = md;
        m_idx  = 0;
      end
      1: begin
        if (sp) begin
          m_ph  = 3;
          m_idx = idx_e;
        end else if (tc_e && !m_cont && (runs + 1) == m_rpt) begin
          m_ph  = 2;
          m_idx = (runs + 1) % 16;
        end else begin
          m_k++;
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    reset    = 1'b1;
    i_start  = 1'b0;
    i_stop   = 1'b0;
    i_mode   = 1'b0;
    i_limit  = '0;
    i_repeat = '0;

    // Reset held for three cycles, released away from the rising edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_zero("rst");

    // One-shot, limit 3, two runs; also a second start while busy.
    cyc(1'b1, 1'b0, 1'b0, 3, 2);
    cyc(1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 9, 7);
    idle_cycles(9);
    check_eq("os_idx_final", o_run_idx, 2);
    idle_cycles(1);

    // Limit 0 with repeat 0: a single terminal count then done.
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    idle_cycles(3);

    // Continuous, limit 15, stopped in cycle 40; start and stop together in IDLE.
    cyc(1'b1, 1'b1, 1'b1, 15, 3);
    idle_cycles(39);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    idle_cycles(3);

    // Stop coincident with the terminal count.
    cyc(1'b1, 1'b0, 1'b0, 2, 4);
    idle_cycles(2);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    check_eq("stop_tc_idx", o_run_idx, 0);
    idle_cycles(3);

    // Asynchronous reset mid-run while count is 5.
    cyc(1'b1, 1'b0, 1'b1, 9, 0);
    idle_cycles(6);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Random traffic, with occasional mid-run asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        check_zero("rnd_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end
      cyc(($urandom_range(0, 3) == 0),
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                      : int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
